// File: rtl/ifq.sv
// Instruction fetch queue: DEPTH-entry circular buffer of {pc, inst} between fetch and decode.
// A redirect flushes all queued entries in one cycle; outputs depend on registered state only.
module ifq #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid_i,
    input  logic [XLEN-1:0]            in_pc_i,
    input  logic [31:0]                in_inst_i,
    output logic                       in_ready_o,
    output logic                       out_valid_o,
    output logic [XLEN-1:0]            out_pc_o,
    output logic [31:0]                out_inst_o,
    input  logic                       out_ready_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int              AW   = $clog2(DEPTH);
    localparam int              CW   = AW + 1;
    localparam logic [CW-1:0]   FULL = CW'(DEPTH);
    localparam logic [31:0]     NOP  = 32'h0000_0013;

    logic [XLEN-1:0] pc_mem_q   [DEPTH];
    logic [31:0]     inst_mem_q [DEPTH];

    logic [AW-1:0] wp_q, wp_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push;
    logic          pop;

    // Ready deliberately ignores flush and out_ready_i: a full queue never accepts, even on a same-cycle pop.
    assign in_ready_o  = (cnt_q != FULL);
    assign out_valid_o = (cnt_q != '0);
    assign push        = in_valid_i & in_ready_o & ~flush_i;
    assign pop         = out_valid_o & out_ready_i & ~flush_i;
    assign count_o     = cnt_q;

    // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
    always_comb begin
        wp_d  = wp_q;
        rp_d  = rp_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) wp_d = wp_q + AW'(1);
            if (pop)  rp_d = rp_q + AW'(1);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            wp_q  <= wp_d;
            rp_q  <= rp_d;
            cnt_q <= cnt_d;
        end
    end

    // NOTE: storage is reset to {0, NOP} on purpose; the array is small, so per-entry reset flops are acceptable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                inst_mem_q[i] <= NOP;
            end
        end else if (push) begin
            pc_mem_q[wp_q]   <= in_pc_i;
            inst_mem_q[wp_q] <= in_inst_i;
        end
    end

    // Empty queue presents a NOP at pc 0 so decode never sees stale storage.
    always_comb begin
        out_pc_o   = '0;
        out_inst_o = NOP;
        if (out_valid_o) begin
            out_pc_o   = pc_mem_q[rp_q];
            out_inst_o = inst_mem_q[rp_q];
        end
    end

endmodule

// File: tb/tb_ifq.sv
// Self-checking bench for ifq: a scoreboard queue models occupancy and ordering,
// compared against the DUT on every falling edge, plus directed checks of the corner cases.
module tb_ifq;

    localparam int          DEPTH = 4;
    localparam int          XLEN  = 32;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [XLEN-1:0] in_pc;
    logic [31:0]     in_inst;
    logic            in_ready;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [31:0]     out_inst;
    logic            out_ready;
    logic            flush;
    logic [2:0]      count;

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];
    int n;

    ifq #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid_i  (in_valid),
        .in_pc_i     (in_pc),
        .in_inst_i   (in_inst),
        .in_ready_o  (in_ready),
        .out_valid_o (out_valid),
        .out_pc_o    (out_pc),
        .out_inst_o  (out_inst),
        .out_ready_i (out_ready),
        .flush_i     (flush),
        .count_o     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return pc ^ 32'h5A5A_0013;
    endfunction

    // Drive one cycle of stimulus; returns just after the following rising edge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic rdy, input logic fl);
        in_valid  = v;
        in_pc     = pc;
        in_inst   = inst_of(pc);
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: compare outputs mid-cycle, then apply the handshakes that the next edge will commit.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            n = sb.size();
            check("count", 64'(count), 64'(n));
            check("in_ready", 64'(in_ready), 64'(n != DEPTH));
            check("out_valid", 64'(out_valid), 64'(n != 0));
            if (n != 0) begin
                check("head_pc", 64'(out_pc), 64'(sb[0][63:32]));
                check("head_inst", 64'(out_inst), 64'(sb[0][31:0]));
            end else begin
                check("empty_pc", 64'(out_pc), 64'd0);
                check("empty_inst", 64'(out_inst), 64'(NOP));
            end
            if (flush) begin
                sb.delete();
            end else begin
                if (n != 0 && out_ready) void'(sb.pop_front());
                if (in_valid && n != DEPTH) sb.push_back({in_pc, in_inst});
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset then idle
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_inst", 64'(out_inst), 64'(NOP));
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_count", 64'(count), 64'd0);

        // Fill, attempt a fifth push, then drain
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h8000_0000 + 32'(4 * i), 1'b0, 1'b0);
        check("fill_count", 64'(count), 64'd4);
        check("fill_ready", 64'(in_ready), 64'd0);
        cycle(1'b1, 32'h8000_0010, 1'b0, 1'b0);
        check("held_count", 64'(count), 64'd4);
        check("held_pc", 64'(out_pc), 64'h8000_0000);
        for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("drain_valid", 64'(out_valid), 64'd0);

        // Streaming across the pointer wrap
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'h8000_1000 + 32'(4 * i), 1'b1, 1'b0);
            check("stream_count", 64'(count), 64'd1);
            check("stream_pc", 64'(out_pc), 64'(32'h8000_1000 + 32'(4 * i)));
        end
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("stream_empty", 64'(out_valid), 64'd0);

        // Full with simultaneous pop: pop accepted, push rejected
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h8000_2000 + 32'(4 * i), 1'b0, 1'b0);
        cycle(1'b1, 32'h8000_2010, 1'b1, 1'b0);
        check("fullpop_count", 64'(count), 64'd3);
        check("fullpop_head", 64'(out_pc), 64'h8000_2004);

        // Flush with concurrent push and pop
        cycle(1'b1, 32'h8000_0100, 1'b1, 1'b1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        cycle(1'b1, 32'h8000_0200, 1'b0, 1'b0);
        check("postflush_valid", 64'(out_valid), 64'd1);
        check("postflush_pc", 64'(out_pc), 64'h8000_0200);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset between edges
        cycle(1'b1, 32'h8000_3000, 1'b0, 1'b0);
        cycle(1'b1, 32'h8000_3004, 1'b0, 1'b0);
        check("pre_rst_count", 64'(count), 64'd2);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(out_valid), 64'd0);
        check("arst_pc", 64'(out_pc), 64'd0);
        check("arst_inst", 64'(out_inst), 64'(NOP));
        check("arst_ready", 64'(in_ready), 64'd1);
        check("arst_count", 64'(count), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        cycle(1'b1, 32'h8000_4000, 1'b0, 1'b0);
        check("post_rst_pc", 64'(out_pc), 64'h8000_4000);
        cycle(1'b0, 32'h0, 1'b1, 1'b0);
        check("final_count", 64'(count), 64'd0);
        @(negedge clk);
        @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
